// File: rtl/pic_usart.sv
// PIC16F946-style asynchronous USART: file-register decode, baud generator,
// 8N1 transmitter and 16x-oversampled receiver feeding a 2-entry RX FIFO.
module pic_usart (
  input  logic       Clk,
  input  logic       nReset,
  input  logic [8:0] File_Address,
  input  logic [7:0] File_Data_In,
  input  logic       File_Latch,
  input  logic       File_Read,
  input  logic       Rx,
  output logic       Tx,
  output logic [7:0] Data_Out,
  output logic       Hit,
  output logic       TXIF,
  output logic       RCIF,
  output logic [1:0] tx_state_dbg,
  output logic [1:0] rx_state_dbg
);

  localparam logic [8:0] A_RCSTA = 9'h018;
  localparam logic [8:0] A_TXREG = 9'h019;
  localparam logic [8:0] A_RCREG = 9'h01A;
  localparam logic [8:0] A_TXSTA = 9'h098;
  localparam logic [8:0] A_SPBRG = 9'h099;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;

  logic       spen, cren, txen, brgh, oerr;
  logic [7:0] spbrg, tx_buf, tx_shreg, rx_shreg;
  logic       tx_full;
  logic [9:0] brg_cnt, brg_limit;
  logic       tick;
  ser_state_t tx_state, tx_nxt, rx_state, rx_nxt;
  logic [3:0] tx_tick, rx_tick;
  logic [2:0] tx_idx, rx_idx;
  logic       tx_load, tx_en, tx_bit_end;
  logic       rx_s1, rx_s2, rx_prev, rx_fall, rx_en, rx_mid, rx_bit_end, rx_push;
  logic [8:0] fifo_mem [2];
  logic       rd_ptr, wr_ptr;
  logic [1:0] fifo_cnt;
  logic       fifo_empty, fifo_full, pop, push_ok, overrun, ferr;

  logic wr_rcsta, wr_txreg, wr_txsta, wr_spbrg;
  assign wr_rcsta = File_Latch && (File_Address == A_RCSTA);
  assign wr_txreg = File_Latch && (File_Address == A_TXREG);
  assign wr_txsta = File_Latch && (File_Address == A_TXSTA);
  assign wr_spbrg = File_Latch && (File_Address == A_SPBRG);

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      spen <= 1'b0; cren <= 1'b0; txen <= 1'b0; brgh <= 1'b0;
      spbrg <= 8'h00; tx_buf <= 8'h00; tx_full <= 1'b0;
    end else begin
      if (wr_rcsta) begin spen <= File_Data_In[7]; cren <= File_Data_In[4]; end
      if (wr_txsta) begin txen <= File_Data_In[5]; brgh <= File_Data_In[2]; end
      if (wr_spbrg) spbrg <= File_Data_In;
      if (wr_txreg) begin
        tx_buf  <= File_Data_In;
        tx_full <= 1'b1;
      end else if (tx_load) begin
        tx_full <= 1'b0;
      end
      // Clearing TXEN or SPEN throws away any pending byte.
      if ((wr_txsta && !File_Data_In[5]) || (wr_rcsta && !File_Data_In[7])) tx_full <= 1'b0;
    end
  end

  // Baud divider: limit is SPBRG (BRGH=1) or 4*(SPBRG+1)-1 (BRGH=0).
  assign brg_limit = brgh ? {2'b00, spbrg} : {spbrg, 2'b11};
  assign tick      = spen && (brg_cnt == brg_limit);

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset)                         brg_cnt <= 10'd0;
    else if (!spen || wr_spbrg || tick)  brg_cnt <= 10'd0;
    else                                 brg_cnt <= brg_cnt + 10'd1;
  end

  // Transmitter
  assign tx_en      = spen && txen;
  assign tx_bit_end = tick && (tx_tick == 4'd15);

  always_comb begin
    tx_nxt  = tx_state;
    tx_load = 1'b0;
    case (tx_state)
      S_IDLE:  if (tx_full) begin tx_load = 1'b1; tx_nxt = S_START; end
      S_START: if (tx_bit_end) tx_nxt = S_DATA;
      S_DATA:  if (tx_bit_end && tx_idx == 3'd7) tx_nxt = S_STOP;
      S_STOP:  if (tx_bit_end) begin
                 if (tx_full) begin tx_load = 1'b1; tx_nxt = S_START; end
                 else tx_nxt = S_IDLE;
               end
      default: tx_nxt = S_IDLE;
    endcase
    if (!tx_en) begin
      tx_nxt  = S_IDLE;
      tx_load = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      tx_state <= S_IDLE; tx_shreg <= 8'h00; tx_tick <= 4'd0; tx_idx <= 3'd0;
    end else begin
      tx_state <= tx_nxt;
      if (tx_load) begin
        tx_shreg <= tx_buf; tx_tick <= 4'd0; tx_idx <= 3'd0;
      end else if (tick) begin
        tx_tick <= tx_tick + 4'd1;
        if (tx_bit_end && tx_state == S_DATA) begin
          tx_shreg <= {1'b0, tx_shreg[7:1]};
          tx_idx   <= tx_idx + 3'd1;
        end
      end
    end
  end

  assign Tx = (tx_state == S_START) ? 1'b0 : (tx_state == S_DATA) ? tx_shreg[0] : 1'b1;

  // Receiver
  assign rx_fall    = rx_prev && !rx_s2;
  assign rx_en      = spen && cren && !oerr;
  assign rx_mid     = tick && (rx_tick == 4'd7);
  assign rx_bit_end = tick && (rx_tick == 4'd15);

  always_comb begin
    rx_nxt  = rx_state;
    rx_push = 1'b0;
    case (rx_state)
      S_IDLE:  if (rx_fall) rx_nxt = S_START;
      S_START: if (rx_mid && rx_s2) rx_nxt = S_IDLE;
               else if (rx_bit_end) rx_nxt = S_DATA;
      S_DATA:  if (rx_bit_end && rx_idx == 3'd7) rx_nxt = S_STOP;
      S_STOP:  if (rx_mid) begin rx_push = 1'b1; rx_nxt = S_IDLE; end
      default: rx_nxt = S_IDLE;
    endcase
    if (!rx_en) begin
      rx_nxt  = S_IDLE;
      rx_push = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
      rx_state <= S_IDLE; rx_tick <= 4'd0; rx_idx <= 3'd0; rx_shreg <= 8'h00;
    end else begin
      rx_s1    <= Rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_nxt;
      if (rx_state == S_IDLE) begin
        rx_tick <= 4'd0; rx_idx <= 3'd0;
      end else if (tick) begin
        rx_tick <= rx_tick + 4'd1;
        if (rx_bit_end && rx_state == S_DATA) rx_idx <= rx_idx + 3'd1;
      end
      if (rx_state == S_DATA && rx_mid) rx_shreg <= {rx_s2, rx_shreg[7:1]};
    end
  end

  // Two-entry FIFO; when full, a same-cycle pop frees the slot the push lands in.
  assign fifo_empty = (fifo_cnt == 2'd0);
  assign fifo_full  = (fifo_cnt == 2'd2);
  assign pop        = File_Read && (File_Address == A_RCREG) && !fifo_empty;
  assign push_ok    = rx_push && (!fifo_full || pop);
  assign overrun    = rx_push && fifo_full && !pop;
  assign wr_ptr     = rd_ptr ^ fifo_cnt[0];

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      fifo_cnt <= 2'd0; rd_ptr <= 1'b0; oerr <= 1'b0;
      fifo_mem[0] <= 9'h000; fifo_mem[1] <= 9'h000;
    end else begin
      if (!spen) begin
        fifo_cnt <= 2'd0; rd_ptr <= 1'b0;
      end else begin
        if (push_ok) fifo_mem[wr_ptr] <= {!rx_s2, rx_shreg};
        if (pop) rd_ptr <= ~rd_ptr;
        fifo_cnt <= fifo_cnt + {1'b0, push_ok} - {1'b0, pop};
      end
      if (!spen || !cren) oerr <= 1'b0;
      else if (overrun)   oerr <= 1'b1;
    end
  end

  assign ferr = !fifo_empty && fifo_mem[rd_ptr][8];
  assign RCIF = !fifo_empty;
  assign TXIF = !tx_full;
  assign tx_state_dbg = tx_state;
  assign rx_state_dbg = rx_state;

  always_comb begin
    Data_Out = 8'h00;
    Hit      = 1'b1;
    case (File_Address)
      A_RCSTA: Data_Out = {spen, 2'b00, cren, 1'b0, ferr, oerr, 1'b0};
      A_TXREG: Data_Out = 8'h00;
      A_RCREG: Data_Out = fifo_empty ? 8'h00 : fifo_mem[rd_ptr][7:0];
      A_TXSTA: Data_Out = {2'b00, txen, 2'b00, brgh, (tx_state == S_IDLE), 1'b0};
      A_SPBRG: Data_Out = spbrg;
      default: Hit = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_pic_usart.sv
// Directed bench for pic_usart: reset, TX framing, back-to-back TX, RX
// loopback, overrun/framing error, false start and mid-frame reset.
module tb_pic_usart;

  logic       Clk = 1'b0;
  logic       nReset = 1'b0;
  logic [8:0] File_Address = 9'h000;
  logic [7:0] File_Data_In = 8'h00;
  logic       File_Latch = 1'b0;
  logic       File_Read = 1'b0;
  logic       Tx, Hit, TXIF, RCIF;
  logic [7:0] Data_Out;
  logic [1:0] tx_state_dbg, rx_state_dbg;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx_line;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  assign rx_line = loop_en ? Tx : rx_drv;

  pic_usart dut (
    .Clk(Clk), .nReset(nReset), .File_Address(File_Address), .File_Data_In(File_Data_In),
    .File_Latch(File_Latch), .File_Read(File_Read), .Rx(rx_line), .Tx(Tx),
    .Data_Out(Data_Out), .Hit(Hit), .TXIF(TXIF), .RCIF(RCIF),
    .tx_state_dbg(tx_state_dbg), .rx_state_dbg(rx_state_dbg)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // All driver tasks are entered at a falling edge and return at one.
  task automatic write_reg(input logic [8:0] a, input logic [7:0] d);
    File_Address = a; File_Data_In = d; File_Latch = 1'b1;
    @(negedge Clk);
    File_Latch = 1'b0;
  endtask

  task automatic pop_rcreg();
    File_Address = 9'h01A; File_Read = 1'b1;
    @(negedge Clk);
    File_Read = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] fw;
    fw = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx_drv = fw[b];
      wait_cycles(16);
    end
    rx_drv = 1'b1;
    wait_cycles(16);
  endtask

  task automatic test_reset();
    @(negedge Clk);
    total++; if (Tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", Tx); end
    total++; if (TXIF !== 1'b1) begin bad++; $display("FAIL reset_txif: got %b want 1", TXIF); end
    total++; if (RCIF !== 1'b0) begin bad++; $display("FAIL reset_rcif: got %b want 0", RCIF); end
    nReset = 1'b1;
    @(negedge Clk);
    File_Address = 9'h098; #1;
    total++; if (Data_Out !== 8'h02) begin bad++; $display("FAIL reset_txsta: got %h want 02", Data_Out); end
    File_Address = 9'h018; #1;
    total++; if (Data_Out !== 8'h00) begin bad++; $display("FAIL reset_rcsta: got %h want 00", Data_Out); end
    File_Address = 9'h099; #1;
    total++; if (Data_Out !== 8'h00) begin bad++; $display("FAIL reset_spbrg: got %h want 00", Data_Out); end
    File_Address = 9'h01A; #1;
    total++; if (Data_Out !== 8'h00 || Hit !== 1'b1) begin bad++; $display("FAIL reset_rcreg: got %h hit %b want 00 hit 1", Data_Out, Hit); end
    File_Address = 9'h01B; #1;
    total++; if (Hit !== 1'b0) begin bad++; $display("FAIL unmapped_hit: got %b want 0", Hit); end
    @(negedge Clk);
  endtask

  task automatic test_tx_frame();
    logic [9:0] fw;
    logic [9:0] bit_bad;
    logic       trmt_bad;
    write_reg(9'h099, 8'h00);
    write_reg(9'h098, 8'h24);
    write_reg(9'h018, 8'h80);
    File_Address = 9'h099; #1;
    total++; if (Data_Out !== 8'h00) begin bad++; $display("FAIL spbrg_rd: got %h want 00", Data_Out); end
    write_reg(9'h019, 8'hA5);
    total++; if (TXIF !== 1'b0) begin bad++; $display("FAIL tx_txif_low: got %b want 0", TXIF); end
    File_Address = 9'h098;
    fw = {1'b1, 8'hA5, 1'b0};
    bit_bad = '0; trmt_bad = 1'b0;
    for (int k = 0; k < 160; k++) begin
      @(negedge Clk);
      if (Tx !== fw[k / 16]) bit_bad[k / 16] = 1'b1;
      if (Data_Out[1] !== 1'b0) trmt_bad = 1'b1;
    end
    for (int b = 0; b < 10; b++) begin
      total++; if (bit_bad[b] !== 1'b0) begin bad++; $display("FAIL tx_bit%0d: Tx differed from %b during bit", b, fw[b]); end
    end
    total++; if (trmt_bad !== 1'b0) begin bad++; $display("FAIL tx_trmt_busy: TRMT seen 1 during frame, want 0"); end
    @(negedge Clk);
    total++; if (Tx !== 1'b1 || Data_Out !== 8'h26) begin bad++; $display("FAIL tx_after_stop: Tx %b TXSTA %h want 1 26", Tx, Data_Out); end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  fw;
    logic [19:0] bit_bad;
    write_reg(9'h019, 8'h01);
    bit_bad = '0;
    for (int k = 0; k < 330; k++) begin
      @(negedge Clk);
      File_Latch = 1'b0;
      fw = (k < 160) ? {1'b1, 8'h01, 1'b0} : {1'b1, 8'h80, 1'b0};
      if (k < 320) begin
        if (Tx !== fw[(k % 160) / 16]) bit_bad[k / 16] = 1'b1;
      end else begin
        if (Tx !== 1'b1) bit_bad[19] = 1'b1;
      end
      if (k == 0) begin
        total++; if (TXIF !== 1'b1) begin bad++; $display("FAIL b2b_first_load_txif: got %b want 1", TXIF); end
        File_Address = 9'h019; File_Data_In = 8'h80; File_Latch = 1'b1;
      end
      if (k == 159) begin
        total++; if (TXIF !== 1'b0) begin bad++; $display("FAIL b2b_pending_txif: got %b want 0", TXIF); end
      end
      if (k == 160) begin
        total++; if (TXIF !== 1'b1 || Tx !== 1'b0) begin bad++; $display("FAIL b2b_second_load: TXIF %b Tx %b want 1 0", TXIF, Tx); end
      end
    end
    for (int b = 0; b < 20; b++) begin
      total++; if (bit_bad[b] !== 1'b0) begin bad++; $display("FAIL b2b_bit%0d: Tx level wrong during bit period", b); end
    end
  endtask

  task automatic test_rx_loopback();
    int n;
    loop_en = 1'b1;
    write_reg(9'h018, 8'h90);
    write_reg(9'h019, 8'h3C);
    n = 0;
    while (RCIF !== 1'b1 && n < 400) begin @(negedge Clk); n++; end
    total++; if (RCIF !== 1'b1) begin bad++; $display("FAIL rx_rcif_timeout: RCIF %b after %0d cycles want 1", RCIF, n); end
    File_Address = 9'h01A; #1;
    total++; if (Data_Out !== 8'h3C) begin bad++; $display("FAIL rx_rcreg: got %h want 3c", Data_Out); end
    File_Address = 9'h018; #1;
    total++; if (Data_Out !== 8'h90) begin bad++; $display("FAIL rx_rcsta_noferr: got %h want 90", Data_Out); end
    pop_rcreg();
    total++; if (RCIF !== 1'b0) begin bad++; $display("FAIL rx_pop_rcif: got %b want 0", RCIF); end
    wait_cycles(40);
    loop_en = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_overrun_framing();
    logic [7:0] e;
    send_frame(8'h11, 1'b1); exp_q.push_back(8'h11);
    send_frame(8'h22, 1'b1); exp_q.push_back(8'h22);
    send_frame(8'h33, 1'b1);
    File_Address = 9'h018; #1;
    total++; if (Data_Out !== 8'h92) begin bad++; $display("FAIL ovr_rcsta: got %h want 92", Data_Out); end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      File_Address = 9'h01A; #1;
      total++; if (Data_Out !== e) begin bad++; $display("FAIL ovr_fifo%0d: got %h want %h", i, Data_Out, e); end
      pop_rcreg();
    end
    total++; if (RCIF !== 1'b0) begin bad++; $display("FAIL ovr_drained: RCIF %b want 0", RCIF); end
    write_reg(9'h018, 8'h80);
    write_reg(9'h018, 8'h90);
    File_Address = 9'h018; #1;
    total++; if (Data_Out !== 8'h90) begin bad++; $display("FAIL oerr_clear: RCSTA %h want 90", Data_Out); end
    send_frame(8'h44, 1'b0);
    File_Address = 9'h018; #1;
    total++; if (Data_Out !== 8'h94) begin bad++; $display("FAIL ferr_set: RCSTA %h want 94", Data_Out); end
    File_Address = 9'h01A; #1;
    total++; if (Data_Out !== 8'h44 || RCIF !== 1'b1) begin bad++; $display("FAIL ferr_data: got %h rcif %b want 44 1", Data_Out, RCIF); end
    pop_rcreg();
    File_Address = 9'h018; #1;
    total++; if (Data_Out !== 8'h90 || RCIF !== 1'b0) begin bad++; $display("FAIL ferr_pop: RCSTA %h rcif %b want 90 0", Data_Out, RCIF); end
  endtask

  task automatic test_false_start();
    rx_drv = 1'b0;
    wait_cycles(4);
    rx_drv = 1'b1;
    wait_cycles(200);
    total++; if (RCIF !== 1'b0) begin bad++; $display("FAIL false_start: RCIF %b want 0", RCIF); end
  endtask

  task automatic test_midframe_reset();
    write_reg(9'h019, 8'h5A);
    wait_cycles(24);
    total++; if (Tx !== 1'b0) begin bad++; $display("FAIL mid_pre: Tx %b want 0 in data bit0", Tx); end
    #2 nReset = 1'b0;
    #1;
    total++; if (Tx !== 1'b1) begin bad++; $display("FAIL mid_reset_tx: Tx %b want 1", Tx); end
    @(negedge Clk);
    nReset = 1'b1;
    @(negedge Clk);
    File_Address = 9'h098; #1;
    total++; if (TXIF !== 1'b1 || Tx !== 1'b1 || RCIF !== 1'b0 || Data_Out !== 8'h02) begin
      bad++; $display("FAIL mid_release: TXIF %b Tx %b RCIF %b TXSTA %h want 1 1 0 02", TXIF, Tx, RCIF, Data_Out);
    end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_rx_loopback();
    test_overrun_framing();
    test_false_start();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
